snax_acc_csr_responder: RTL and testbench



---
 rtl/snax_acc_csr_responder_if.sv | 41 ++++
 rtl/snax_acc_csr_responder.sv | 166 ++++++++++++++++
 tb/tb_snax_acc_csr_responder.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snax_acc_csr_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : snax_acc_csr_responder_if
// Description : CSR request/response bundle between the SNAX offload port
//               (master) and an accelerator CSR endpoint (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface snax_acc_csr_responder_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 5
) ();
    logic [AddrWidth-1:0] req_addr_i;
    logic                 req_write_i;
    logic [DataWidth-1:0] req_wdata_i;
    logic [IdWidth-1:0]   req_id_i;
    logic                 req_qvalid_i;
    logic                 req_qready_o;
    logic [DataWidth-1:0] resp_data_o;
    logic [IdWidth-1:0]   resp_id_o;
    logic                 resp_error_o;
    logic                 resp_pvalid_o;
    logic                 resp_pready_i;

    // Requester side: drives requests, consumes responses
    modport master (
        output req_addr_i, req_write_i, req_wdata_i, req_id_i, req_qvalid_i,
        output resp_pready_i,
        input  req_qready_o,
        input  resp_data_o, resp_id_o, resp_error_o, resp_pvalid_o
    );

    // Responder side: accepts requests, produces responses
    modport slave (
        input  req_addr_i, req_write_i, req_wdata_i, req_id_i, req_qvalid_i,
        input  resp_pready_i,
        output req_qready_o,
        output resp_data_o, resp_id_o, resp_error_o, resp_pvalid_o
    );
endinterface
`default_nettype wire

// File: rtl/snax_acc_csr_responder.sv
`default_nettype none
// ============================================================================
// Module      : snax_acc_csr_responder
// Description : Accelerator-side CSR endpoint. Holds config registers, a
//               START launch/status register and a PERF run-length counter,
//               and answers reads through a one-entry response buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module snax_acc_csr_responder #(
    parameter int unsigned NumCsrs       = 32,
    parameter int unsigned CsrAddrOffset = 0,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned IdWidth       = 5
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    snax_acc_csr_responder_if.slave           bus,
    output logic [(NumCsrs-2)*DataWidth-1:0]  csr_reg_o,
    output logic                              acc_start_valid_o,
    input  logic                              acc_start_ready_i,
    input  logic                              acc_done_i,
    output logic                              acc_busy_o
);

    localparam int unsigned          NUM_CFG     = NumCsrs - 2;
    localparam logic [AddrWidth-1:0] ADDR_OFFSET = AddrWidth'(CsrAddrOffset);
    localparam logic [AddrWidth-1:0] NUM_SLOTS   = AddrWidth'(NumCsrs);
    localparam logic [AddrWidth-1:0] START_IDX   = AddrWidth'(NumCsrs - 2);
    localparam logic [AddrWidth-1:0] PERF_IDX    = AddrWidth'(NumCsrs - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [DataWidth-1:0] perf_q, perf_d;
    logic [DataWidth-1:0] cfg_q [NUM_CFG];
    logic [DataWidth-1:0] cfg_d [NUM_CFG];
    logic                 resp_valid_q, resp_valid_d;
    logic [DataWidth-1:0] resp_data_q, resp_data_d;
    logic [IdWidth-1:0]   resp_id_q, resp_id_d;
    logic                 resp_err_q, resp_err_d;

    logic [AddrWidth-1:0] idx;
    logic                 in_range, is_cfg, is_start, is_perf;
    logic                 req_ready, wr_acc, rd_acc;
    logic [DataWidth-1:0] rdata;

    // Address decode relative to this instance's window
    always_comb begin
        idx      = bus.req_addr_i - ADDR_OFFSET;
        in_range = (bus.req_addr_i >= ADDR_OFFSET) && (idx < NUM_SLOTS);
        is_cfg   = in_range && (idx < START_IDX);
        is_start = in_range && (idx == START_IDX);
        is_perf  = in_range && (idx == PERF_IDX);
    end

    // Writes stall while a run is in flight; reads only need buffer space
    always_comb begin
        req_ready = bus.req_write_i ? (state_q == ST_IDLE)
                                    : (!resp_valid_q || bus.resp_pready_i);
        wr_acc    = bus.req_qvalid_i && req_ready && bus.req_write_i;
        rd_acc    = bus.req_qvalid_i && req_ready && !bus.req_write_i;
    end

    // Read data mux, sampled from the current register/state values
    always_comb begin
        rdata = '0;
        if (is_cfg) begin
            for (int k = 0; k < int'(NUM_CFG); k++) begin
                if (idx == AddrWidth'(k)) rdata = cfg_q[k];
            end
        end else if (is_start) begin
            rdata[0] = (state_q != ST_IDLE);
            rdata[1] = (state_q == ST_LAUNCH);
        end else if (is_perf) begin
            rdata = perf_q;
        end
    end

    // Config register writes; START/PERF/out-of-range writes store nothing
    always_comb begin
        for (int k = 0; k < int'(NUM_CFG); k++) begin
            cfg_d[k] = cfg_q[k];
            if (wr_acc && is_cfg && (idx == AddrWidth'(k))) cfg_d[k] = bus.req_wdata_i;
        end
    end

    // Launch FSM and PERF counter (cleared at handshake, saturating in BUSY)
    always_comb begin
        state_d = state_q;
        perf_d  = perf_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_acc && is_start && bus.req_wdata_i[0]) state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                if (acc_start_ready_i) begin
                    state_d = ST_BUSY;
                    perf_d  = '0;
                end
            end
            ST_BUSY: begin
                if (perf_q != '1) perf_d = perf_q + 1'b1;
                if (acc_done_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // One-entry response buffer: drain and refill may happen in one cycle
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        resp_err_d   = resp_err_q;
        if (resp_valid_q && bus.resp_pready_i) resp_valid_d = 1'b0;
        if (rd_acc) begin
            resp_valid_d = 1'b1;
            resp_data_d  = rdata;
            resp_id_d    = bus.req_id_i;
            resp_err_d   = !in_range;
        end
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            perf_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            resp_err_q   <= 1'b0;
            for (int k = 0; k < int'(NUM_CFG); k++) cfg_q[k] <= '0;
        end else begin
            state_q      <= state_d;
            perf_q       <= perf_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            resp_err_q   <= resp_err_d;
            for (int k = 0; k < int'(NUM_CFG); k++) cfg_q[k] <= cfg_d[k];
        end
    end

    // Flatten config registers onto the output bus
    generate
        for (genvar g = 0; g < int'(NUM_CFG); g++) begin : g_csr_out
            assign csr_reg_o[g*DataWidth +: DataWidth] = cfg_q[g];
        end
    endgenerate

    assign bus.req_qready_o  = req_ready;
    assign bus.resp_pvalid_o = resp_valid_q;
    assign bus.resp_data_o   = resp_data_q;
    assign bus.resp_id_o     = resp_id_q;
    assign bus.resp_error_o  = resp_err_q;
    assign acc_start_valid_o = (state_q == ST_LAUNCH);
    assign acc_busy_o        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_snax_acc_csr_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_snax_acc_csr_responder
// Description : Directed + randomized bench for snax_acc_csr_responder with a
//               behavioural register/run/response model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snax_acc_csr_responder;
    localparam int NUM_CSRS  = 32;
    localparam int OFFSET    = 16;
    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int IW        = 5;
    localparam int NCFG      = NUM_CSRS - 2;
    localparam int START_IDX = NUM_CSRS - 2;
    localparam int PERF_IDX  = NUM_CSRS - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 start_ready, done;
    logic                 start_valid, busy;
    logic [NCFG*DW-1:0]   csr_reg;

    snax_acc_csr_responder_if #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) bus ();

    snax_acc_csr_responder #(
        .NumCsrs(NUM_CSRS), .CsrAddrOffset(OFFSET),
        .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .bus               (bus),
        .csr_reg_o         (csr_reg),
        .acc_start_valid_o (start_valid),
        .acc_start_ready_i (start_ready),
        .acc_done_i        (done),
        .acc_busy_o        (busy)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic          err;
    } resp_t;

    // Behavioural model: register file, run phase (0 idle, 1 waiting for the
    // datapath, 2 running), handshake timestamp, and pending responses.
    logic [DW-1:0] m_cfg [NCFG];
    logic [DW-1:0] m_perf;
    int            m_phase;
    int            cyc, m_hs_cyc;
    resp_t         m_q[$];

    int  checks = 0;
    int  errors = 0;
    bit  last_hs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic resp_t model_read(input logic [AW-1:0] addr, input logic [IW-1:0] id);
        longint a, i;
        resp_t  r;
        a      = longint'(addr);
        r.id   = id;
        r.data = '0;
        r.err  = 1'b0;
        if (a < OFFSET || a - OFFSET >= NUM_CSRS) begin
            r.err = 1'b1;
        end else begin
            i = a - OFFSET;
            if (i < NCFG)              r.data = m_cfg[i];
            else if (i == START_IDX)   r.data = {30'b0, m_phase == 1, m_phase != 0};
            else                       r.data = m_perf;
        end
        return r;
    endfunction

    task automatic check_outputs();
        chk("resp_pvalid", bus.resp_pvalid_o, m_q.size() != 0);
        if (m_q.size() != 0) begin
            chk("resp_data",  bus.resp_data_o,  m_q[0].data);
            chk("resp_id",    bus.resp_id_o,    m_q[0].id);
            chk("resp_error", bus.resp_error_o, m_q[0].err);
        end
        chk("acc_busy",        busy,        m_phase != 0);
        chk("acc_start_valid", start_valid, m_phase == 1);
        for (int k = 0; k < NCFG; k++)
            chk($sformatf("csr_reg[%0d]", k), csr_reg[k*DW +: DW], m_cfg[k]);
    endtask

    // One clock cycle: check ready, advance the model across the edge, check outputs
    task automatic tick();
        logic   exp_rdy;
        longint a, i;
        int     old_phase;
        #1;
        exp_rdy = bus.req_write_i ? (m_phase == 0) : (m_q.size() == 0 || bus.resp_pready_i);
        chk("req_qready", bus.req_qready_o, exp_rdy);
        last_hs   = bus.req_qvalid_i && exp_rdy;
        old_phase = m_phase;
        if (m_q.size() != 0 && bus.resp_pready_i) void'(m_q.pop_front());
        if (last_hs && !bus.req_write_i) m_q.push_back(model_read(bus.req_addr_i, bus.req_id_i));
        if (last_hs && bus.req_write_i) begin
            a = longint'(bus.req_addr_i);
            if (a >= OFFSET && a - OFFSET < NUM_CSRS) begin
                i = a - OFFSET;
                if (i < NCFG) m_cfg[i] = bus.req_wdata_i;
                else if (i == START_IDX && bus.req_wdata_i[0]) m_phase = 1;
            end
        end
        @(posedge clk);
        cyc++;
        if (old_phase == 1 && start_ready) begin
            m_phase  = 2;
            m_hs_cyc = cyc;
            m_perf   = '0;
        end else if (old_phase == 2) begin
            m_perf = DW'(cyc - m_hs_cyc);
            if (done) m_phase = 0;
        end
        #1;
        check_outputs();
    endtask

    task automatic set_req(input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [IW-1:0] id);
        bus.req_qvalid_i = 1'b1;
        bus.req_write_i  = wr;
        bus.req_addr_i   = addr;
        bus.req_wdata_i  = wdata;
        bus.req_id_i     = id;
    endtask

    // Present a request until accepted (bounded), then withdraw it
    task automatic do_req(input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [IW-1:0] id);
        bit ok = 0;
        set_req(wr, addr, wdata, id);
        for (int n = 0; n < 50 && !ok; n++) begin
            tick();
            ok = last_hs;
        end
        if (!ok) chk("req_accept_timeout", 0, 1);
        bus.req_qvalid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.req_qvalid_i = 1'b0;
        start_ready      = 1'b0;
        done             = 1'b0;
        @(posedge clk);
        cyc++;
        for (int k = 0; k < NCFG; k++) m_cfg[k] = '0;
        m_perf  = '0;
        m_phase = 0;
        m_q.delete();
        #1;
        rst = 1'b0;
        check_outputs();
        chk("rst_resp_data",  bus.resp_data_o,  0);
        chk("rst_resp_id",    bus.resp_id_o,    0);
        chk("rst_resp_error", bus.resp_error_o, 0);
    endtask

    initial begin
        cyc              = 0;
        m_hs_cyc         = 0;
        bus.req_addr_i   = '0;
        bus.req_write_i  = 1'b0;
        bus.req_wdata_i  = '0;
        bus.req_id_i     = '0;
        bus.req_qvalid_i = 1'b0;
        bus.resp_pready_i = 1'b1;
        start_ready      = 1'b0;
        done             = 1'b0;
        rst              = 1'b1;
        do_reset();

        // Config write then read-back
        do_req(1, OFFSET + 3, 32'hDEADBEEF, 0);
        do_req(1, OFFSET + 0, 32'h11111111, 0);
        do_req(0, OFFSET + 3, 0, 7);
        chk("rd3_data", bus.resp_data_o, 32'hDEADBEEF);
        chk("rd3_id",   bus.resp_id_o,   7);
        chk("rd3_err",  bus.resp_error_o, 0);

        // Out-of-range accesses and inert writes
        do_req(0, OFFSET + NUM_CSRS, 0, 2);
        chk("oor_data", bus.resp_data_o, 0);
        chk("oor_err",  bus.resp_error_o, 1);
        do_req(0, OFFSET - 1, 0, 6);
        chk("below_err", bus.resp_error_o, 1);
        do_req(1, OFFSET + 40, 32'h12345678, 0);
        chk("oor_wr_no_resp", bus.resp_pvalid_o, 0);
        do_req(1, OFFSET + START_IDX, 32'hFFFF_FFFE, 0);
        chk("start_bit0_zero", busy, 0);
        do_req(1, OFFSET + PERF_IDX, 32'hAAAA5555, 0);
        do_req(0, OFFSET + PERF_IDX, 0, 1);
        chk("perf_ro", bus.resp_data_o, 0);

        // Launch with datapath stalled 3 cycles, then a 5-cycle run
        do_req(1, OFFSET + START_IDX, 1, 0);
        chk("launch_valid", start_valid, 1);
        do_req(0, OFFSET + START_IDX, 0, 3);
        chk("start_rd_launch", bus.resp_data_o, 3);
        tick();
        tick();
        start_ready = 1'b1;
        tick();
        start_ready = 1'b0;
        chk("hs_start_valid", start_valid, 0);
        chk("hs_busy", busy, 1);
        do_req(0, OFFSET + START_IDX, 0, 4);
        chk("start_rd_busy", bus.resp_data_o, 1);
        do_req(0, OFFSET + 0, 0, 5);
        chk("rd0_busy", bus.resp_data_o, 32'h11111111);
        set_req(1, OFFSET + 0, 32'hCAFEF00D, 0);
        tick();
        chk("busy_wr_stall0", last_hs, 0);
        tick();
        chk("busy_wr_stall1", last_hs, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("busy_wr_stall2", last_hs, 0);
        chk("idle_after_done", busy, 0);
        tick();
        chk("wr_after_done", last_hs, 1);
        bus.req_qvalid_i = 1'b0;
        chk("csr0_new", csr_reg[31:0], 32'hCAFEF00D);
        do_req(0, OFFSET + PERF_IDX, 0, 8);
        chk("perf_5", bus.resp_data_o, 5);
        do_req(0, OFFSET + START_IDX, 0, 9);
        chk("start_rd_idle", bus.resp_data_o, 0);
        tick();

        // Three back-to-back reads with a stalled consumer
        bus.resp_pready_i = 1'b0;
        do_req(0, OFFSET + 3, 0, 1);
        set_req(0, OFFSET + 0, 0, 2);
        tick();
        chk("bb_stall0", last_hs, 0);
        chk("bb_hold_id0", bus.resp_id_o, 1);
        tick();
        chk("bb_stall1", last_hs, 0);
        chk("bb_hold_data", bus.resp_data_o, 32'hDEADBEEF);
        bus.resp_pready_i = 1'b1;
        tick();
        chk("bb_accept2", last_hs, 1);
        chk("bb_id2", bus.resp_id_o, 2);
        set_req(0, OFFSET + 1, 0, 3);
        tick();
        chk("bb_accept3", last_hs, 1);
        chk("bb_id3", bus.resp_id_o, 3);
        bus.req_qvalid_i = 1'b0;
        tick();
        chk("bb_drained", bus.resp_pvalid_o, 0);

        // Reset while running with a response pending
        start_ready = 1'b1;
        do_req(1, OFFSET + START_IDX, 1, 0);
        tick();
        start_ready = 1'b0;
        tick();
        bus.resp_pready_i = 1'b0;
        do_req(0, OFFSET + 3, 0, 9);
        chk("pre_rst_pending", bus.resp_pvalid_o, 1);
        chk("pre_rst_busy", busy, 1);
        do_reset();
        bus.resp_pready_i = 1'b1;
        do_req(0, OFFSET + PERF_IDX, 0, 10);
        chk("rst_perf", bus.resp_data_o, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            int unsigned r;
            logic [AW-1:0] addr;
            r = $urandom_range(0, 99);
            if (r < 80)      addr = AW'(OFFSET + $urandom_range(0, NUM_CSRS - 1));
            else if (r < 90) addr = AW'(OFFSET + START_IDX);
            else             addr = $urandom;
            bus.req_qvalid_i  = ($urandom_range(0, 1) == 1);
            bus.req_write_i   = ($urandom_range(0, 9) < 4);
            bus.req_addr_i    = addr;
            bus.req_wdata_i   = $urandom;
            bus.req_id_i      = IW'($urandom);
            bus.resp_pready_i = ($urandom_range(0, 9) < 7);
            start_ready       = ($urandom_range(0, 1) == 1);
            done              = ($urandom_range(0, 9) == 0);
            tick();
        end
        bus.req_qvalid_i  = 1'b0;
        bus.resp_pready_i = 1'b1;
        start_ready       = 1'b0;
        done              = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
